// File: rtl/ula_seq_if.sv
// ula_seq_if: operation request / result bundle between the datapath control
// and the registered ALU.
//   start      request (ignored while busy)
//   operacao   3-bit operation select
//   a          first operand (A register)
//   bus_wires  second operand (BusWires)
//   q          registered result
//   done       one-cycle completion pulse
//   busy       multiply in progress
//   z,n,c,v    zero / negative / carry / overflow flags, registered with q
interface ula_seq_if #(
    parameter int unsigned WIDTH = 16
);
    logic             start;
    logic [2:0]       operacao;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] bus_wires;
    logic [WIDTH-1:0] q;
    logic             done;
    logic             busy;
    logic             z;
    logic             n;
    logic             c;
    logic             v;

    modport master (
        output start, operacao, a, bus_wires,
        input  q, done, busy, z, n, c, v
    );

    modport slave (
        input  start, operacao, a, bus_wires,
        output q, done, busy, z, n, c, v
    );
endinterface

// File: rtl/ula_seq.sv
// ula_seq: registered ALU with Start/Done handshake, condition flags and a
// multi-cycle shift-add multiplier.
//   Clock  rising-edge clock
//   Reset  asynchronous active-high reset; aborts any running multiply
//   bus    ula_seq_if slave: start/operacao/a/bus_wires in,
//          q/done/busy/z/n/c/v out (all registered)
module ula_seq #(
    parameter int unsigned WIDTH = 16
) (
    input  logic       Clock,
    input  logic       Reset,
    ula_seq_if.slave   bus
);
    localparam int unsigned SHW = $clog2(WIDTH);
    localparam int unsigned CW  = $clog2(WIDTH) + 1;
    localparam int unsigned EW  = WIDTH + 1;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_SLT = 3'b101;
    localparam logic [2:0] OP_SHL = 3'b110;
    localparam logic [2:0] OP_MUL = 3'b111;

    typedef enum logic {IDLE, MUL} state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0] mplier_q, mplier_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             z_q, z_d, n_q, n_d, c_q, c_d, v_q, v_d;
    logic             done_q, done_d;
    logic             busy_q, busy_d;

    logic [WIDTH-1:0] alu_res;
    logic             alu_c;
    logic             alu_v;
    logic [WIDTH:0]   ext;
    logic [WIDTH-1:0] acc_next;

    // Single-cycle datapath, evaluated directly on the live operand inputs.
    always_comb begin
        alu_res = '0;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        ext     = '0;
        case (bus.operacao)
            OP_ADD: begin
                ext     = {1'b0, bus.a} + {1'b0, bus.bus_wires};
                alu_res = ext[WIDTH-1:0];
                alu_c   = ext[WIDTH];
                alu_v   = (bus.a[WIDTH-1] == bus.bus_wires[WIDTH-1]) &&
                          (alu_res[WIDTH-1] != bus.a[WIDTH-1]);
            end
            OP_SUB: begin
                ext     = {1'b0, bus.a} + {1'b0, ~bus.bus_wires} + EW'(1);
                alu_res = ext[WIDTH-1:0];
                alu_c   = ext[WIDTH];
                alu_v   = (bus.a[WIDTH-1] != bus.bus_wires[WIDTH-1]) &&
                          (alu_res[WIDTH-1] != bus.a[WIDTH-1]);
            end
            OP_AND:  alu_res = bus.a & bus.bus_wires;
            OP_OR:   alu_res = bus.a | bus.bus_wires;
            OP_XOR:  alu_res = bus.a ^ bus.bus_wires;
            OP_SLT:  alu_res = WIDTH'($signed(bus.a) < $signed(bus.bus_wires));
            OP_SHL:  alu_res = bus.a << bus.bus_wires[SHW-1:0];
            default: alu_res = '0;
        endcase
    end

    // One shift-add step: conditional add of the multiplicand.
    always_comb begin
        acc_next = acc_q;
        if (mplier_q[0]) begin
            acc_next = acc_q + mcand_q;
        end
    end

    // Next-state and output logic.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        res_d    = res_q;
        z_d      = z_q;
        n_d      = n_q;
        c_d      = c_q;
        v_d      = v_q;
        done_d   = 1'b0;
        busy_d   = busy_q;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    if (bus.operacao == OP_MUL) begin
                        mcand_d  = bus.a;
                        mplier_d = bus.bus_wires;
                        acc_d    = '0;
                        cnt_d    = CW'(WIDTH);
                        busy_d   = 1'b1;
                        state_d  = MUL;
                    end else begin
                        res_d  = alu_res;
                        z_d    = (alu_res == '0);
                        n_d    = alu_res[WIDTH-1];
                        c_d    = alu_c;
                        v_d    = alu_v;
                        done_d = 1'b1;
                    end
                end
            end
            MUL: begin
                acc_d    = acc_next;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q - CW'(1);
                // Last step: the final partial sum goes straight to the result.
                if (cnt_q == CW'(1)) begin
                    res_d   = acc_next;
                    z_d     = (acc_next == '0);
                    n_d     = acc_next[WIDTH-1];
                    c_d     = 1'b0;
                    v_d     = 1'b0;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and result registers.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            res_q    <= '0;
            z_q      <= 1'b0;
            n_q      <= 1'b0;
            c_q      <= 1'b0;
            v_q      <= 1'b0;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            res_q    <= res_d;
            z_q      <= z_d;
            n_q      <= n_d;
            c_q      <= c_d;
            v_q      <= v_d;
            done_q   <= done_d;
            busy_q   <= busy_d;
        end
    end

    assign bus.q    = res_q;
    assign bus.z    = z_q;
    assign bus.n    = n_q;
    assign bus.c    = c_q;
    assign bus.v    = v_q;
    assign bus.done = done_q;
    assign bus.busy = busy_q;
endmodule

// File: tb/tb_ula_seq.sv
// tb_ula_seq: directed plus randomized checks of ula_seq at WIDTH=16 and
// WIDTH=8 against an arithmetic reference model.
module tb_ula_seq;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    ula_seq_if #(.WIDTH(16)) b16 ();
    ula_seq_if #(.WIDTH(8))  b8 ();

    ula_seq #(.WIDTH(16)) dut16 (.Clock(clk), .Reset(rst), .bus(b16.slave));
    ula_seq #(.WIDTH(8))  dut8  (.Clock(clk), .Reset(rst), .bus(b8.slave));

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [63:0] q;
        logic        z;
        logic        n;
        logic        c;
        logic        v;
    } res_t;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: plain integer arithmetic on unsigned and signed views.
    function automatic res_t model(input int op, input longint a, input longint b, input int w);
        longint m, half, sa, sb, s;
        res_t r;
        m    = (longint'(1) << w) - 1;
        half = longint'(1) << (w - 1);
        sa   = (a >= half) ? a - 2 * half : a;
        sb   = (b >= half) ? b - 2 * half : b;
        r    = '0;
        case (op)
            0: begin
                s = a + b; r.q = s & m; r.c = (s > m);
                s = sa + sb; r.v = (s >= half) || (s < -half);
            end
            1: begin
                r.q = (a - b) & m; r.c = (a >= b);
                s = sa - sb; r.v = (s >= half) || (s < -half);
            end
            2: r.q = a & b;
            3: r.q = a | b;
            4: r.q = a ^ b;
            5: r.q = (sa < sb) ? 64'd1 : 64'd0;
            6: r.q = (a << (b % w)) & m;
            default: r.q = (a * b) & m;
        endcase
        r.z = (r.q == 0);
        r.n = (longint'(r.q) >= half);
        return r;
    endfunction

    // Issue a single-cycle op at a negedge; check the Done cycle.
    task automatic single16(input int op, input longint a, input longint b);
        res_t e;
        b16.operacao  = 3'(op);
        b16.a         = 16'(a);
        b16.bus_wires = 16'(b);
        b16.start     = 1'b1;
        @(negedge clk);
        b16.start = 1'b0;
        e = model(op, a, b, 16);
        chk($sformatf("op%0d_done", op), 64'(b16.done), 64'd1);
        chk($sformatf("op%0d_busy", op), 64'(b16.busy), 64'd0);
        chk($sformatf("op%0d_q a=%0h b=%0h", op, a, b), 64'(b16.q), e.q);
        chk($sformatf("op%0d_flags a=%0h b=%0h", op, a, b),
            64'({b16.z, b16.n, b16.c, b16.v}), 64'({e.z, e.n, e.c, e.v}));
    endtask

    // Multiply on the 16-bit unit, optionally pulsing Start mid-flight.
    task automatic mul16(input longint a, input longint b, input bit inject);
        res_t e;
        int first_done, ndone, bad_busy, overlap;
        logic [15:0] q17;
        logic [3:0]  f17;
        e = model(7, a, b, 16);
        first_done = 0; ndone = 0; bad_busy = 0; overlap = 0;
        q17 = '0; f17 = '0;
        b16.operacao  = 3'b111;
        b16.a         = 16'(a);
        b16.bus_wires = 16'(b);
        b16.start     = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (i == 1) begin
                b16.start = 1'b0;
                b16.a = 16'($urandom);
                b16.bus_wires = 16'($urandom);
            end
            if (b16.done && first_done == 0) first_done = i;
            if (b16.done) ndone++;
            if (b16.done && b16.busy) overlap++;
            if ((i <= 16 && !b16.busy) || (i > 16 && b16.busy)) bad_busy++;
            if (i == 17) begin
                q17 = b16.q;
                f17 = {b16.z, b16.n, b16.c, b16.v};
            end
            if (inject && i == 8) begin
                b16.operacao = 3'b000;
                b16.a = 16'h1111;
                b16.bus_wires = 16'h2222;
                b16.start = 1'b1;
            end
            if (inject && i == 9) b16.start = 1'b0;
        end
        chk($sformatf("mul_busy_window %0h*%0h", a, b), 64'(bad_busy), 64'd0);
        chk("mul_done_cycle", 64'(first_done), 64'd17);
        chk("mul_done_count", 64'(ndone), 64'd1);
        chk("mul_busy_done_overlap", 64'(overlap), 64'd0);
        chk($sformatf("mul_q %0h*%0h", a, b), 64'(q17), e.q);
        chk("mul_flags", 64'(f17), 64'({e.z, e.n, e.c, e.v}));
    endtask

    initial begin
        int first_done;
        logic [7:0] q9;
        rst = 1'b1;
        b16.start = 1'b0; b16.operacao = '0; b16.a = '0; b16.bus_wires = '0;
        b8.start  = 1'b0; b8.operacao  = '0; b8.a  = '0; b8.bus_wires  = '0;
        repeat (2) @(negedge clk);
        chk("reset_q", 64'(b16.q), 64'd0);
        chk("reset_flags", 64'({b16.z, b16.n, b16.c, b16.v}), 64'd0);
        chk("reset_done_busy", 64'({b16.done, b16.busy}), 64'd0);
        rst = 1'b0;
        @(negedge clk);

        // Add overflow, then Done must drop.
        single16(0, 'h7FFF, 'h0001);
        @(negedge clk);
        chk("done_single_pulse", 64'(b16.done), 64'd0);

        // Sub equal, then back-to-back sub with borrow in the Done cycle.
        single16(1, 5, 5);
        single16(1, 3, 5);
        @(negedge clk);

        single16(4, 'hF0F0, 'h0FF0);
        single16(5, 'hFFFF, 'h0001);
        single16(6, 'h0001, 'h0013);
        @(negedge clk);

        mul16(300, 200, 1'b0);
        mul16('h0100, 'h0100, 1'b0);
        mul16('h1234, 'h00FF, 1'b1);

        for (int i = 0; i < 30; i++) begin
            int op;
            longint a, b;
            op = int'($urandom_range(0, 7));
            a  = longint'($urandom_range(0, 16'hFFFF));
            b  = longint'($urandom_range(0, 16'hFFFF));
            if (op == 7) mul16(a, b, 1'b0);
            else single16(op, a, b);
        end
        @(negedge clk);

        // Reset in the middle of a multiply, with a nonzero result held.
        single16(0, 1, 1);
        b16.operacao = 3'b111; b16.a = 16'h1234; b16.bus_wires = 16'h5678;
        b16.start = 1'b1;
        @(negedge clk);
        b16.start = 1'b0;
        repeat (7) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rst_mid_q", 64'(b16.q), 64'd0);
        chk("rst_mid_flags", 64'({b16.z, b16.n, b16.c, b16.v}), 64'd0);
        chk("rst_mid_done_busy", 64'({b16.done, b16.busy}), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        single16(0, 2, 3);
        @(negedge clk);

        // 8-bit instance: 15*17, Done on the 9th cycle.
        b8.operacao = 3'b111; b8.a = 8'd15; b8.bus_wires = 8'd17; b8.start = 1'b1;
        first_done = 0; q9 = '0;
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            if (i == 1) b8.start = 1'b0;
            if (b8.done && first_done == 0) begin
                first_done = i;
                q9 = b8.q;
            end
        end
        chk("w8_done_cycle", 64'(first_done), 64'd9);
        chk("w8_q", 64'(q9), model(7, 15, 17, 8).q);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
